payload_aligner: RTL and testbench

//  Parametrised header-strip/realign stage with full valid/ready backpressure. Sits between the

---
 rtl/payload_aligner_if.sv | 30 +++
 rtl/payload_aligner.sv | 183 ++++++++++++++++++
 tb/tb_payload_aligner.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/payload_aligner_if.sv
// rtl/payload_aligner_if.sv - stream bus for payload_aligner (input flits, output flits, backpressure)
interface payload_aligner_if #(
  parameter int DATA_W  = 512,
  parameter int HDR_W   = 9,
  parameter int EMPTY_W = $clog2(DATA_W/8)
);
  logic [HDR_W-1:0]   in_hdr_len;
  logic               in_sop;
  logic               in_eop;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic [EMPTY_W-1:0] in_empty;
  logic               in_ready;
  logic               out_sop;
  logic               out_eop;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [EMPTY_W-1:0] out_empty;
  logic               out_ready;

  modport master (
    output in_hdr_len, in_sop, in_eop, in_valid, in_data, in_empty, out_ready,
    input  in_ready, out_sop, out_eop, out_valid, out_data, out_empty
  );

  modport slave (
    input  in_hdr_len, in_sop, in_eop, in_valid, in_data, in_empty, out_ready,
    output in_ready, out_sop, out_eop, out_valid, out_data, out_empty
  );
endinterface

// File: rtl/payload_aligner.sv
// rtl/payload_aligner.sv - strips a per-packet byte header and re-emits the payload left-aligned
// Optional feature macro PAYLOAD_ALIGNER_STATS_EN adds stat_pkt_cnt / stat_drop_cnt outputs.
module payload_aligner #(
  parameter int DATA_W  = 512,
  parameter int HDR_W   = 9,
  parameter int EMPTY_W = $clog2(DATA_W/8)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PAYLOAD_ALIGNER_STATS_EN
  output logic [31:0]      stat_pkt_cnt,
  output logic [31:0]      stat_drop_cnt,
`endif
  payload_aligner_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int RW    = LB + 2;
  localparam int SW    = HDR_W - LB;
  localparam logic [RW-1:0] BYTES_R = RW'(BYTES);

  typedef enum logic [1:0] {S_HEAD, S_ACC, S_FLUSH} state_t;

  state_t             r_state, w_nstate;
  logic [HDR_W-1:0]   r_cnt, w_n_cnt, w_idx;
  logic [SW-1:0]      r_skip, w_skip;
  logic [LB-1:0]      r_off, w_off;
  logic [RW-1:0]      r_res, w_n_res, w_vb, w_total;
  logic [DATA_W-1:0]  r_res_data, w_n_res_data, w_mask, w_cat;
  logic               r_first, w_n_first;
  logic               r_out_valid, r_out_sop, r_out_eop;
  logic [EMPTY_W-1:0] r_out_empty;
  logic [DATA_W-1:0]  r_out_data;
  logic               w_ld, w_in_ready, w_acc, w_drop;
  logic               w_emit, w_e_sop, w_e_eop;
  logic [EMPTY_W-1:0] w_e_empty;
  logic [DATA_W-1:0]  w_e_data;

  always_comb begin
    w_ld       = !r_out_valid || bus.out_ready;
    w_in_ready = rst_n && w_ld && (r_state != S_FLUSH);
    w_acc      = bus.in_valid && w_in_ready;
    w_vb       = bus.in_eop ? BYTES_R - RW'(bus.in_empty) : BYTES_R;
    w_off      = bus.in_sop ? bus.in_hdr_len[LB-1:0] : r_off;
    w_skip     = bus.in_sop ? bus.in_hdr_len[HDR_W-1:LB] : r_skip;
    w_idx      = bus.in_sop ? '0 : r_cnt;
    w_total    = r_res + w_vb;
    // residual bytes live at the MSB end; bytes past r_res are stale and masked here
    w_mask     = ~({DATA_W{1'b1}} >> {r_res, 3'b000});
    w_cat      = (r_res_data & w_mask) | (bus.in_data >> {r_res, 3'b000});

    w_nstate     = r_state;
    w_n_cnt      = r_cnt;
    w_n_res      = r_res;
    w_n_res_data = r_res_data;
    w_n_first    = r_first;
    w_drop       = 1'b0;
    w_emit       = 1'b0;
    w_e_sop      = 1'b0;
    w_e_eop      = 1'b0;
    w_e_empty    = '0;
    w_e_data     = w_cat;

    if (r_state == S_FLUSH) begin
      if (w_ld) begin
        w_emit    = 1'b1;
        w_e_data  = r_res_data & w_mask;
        w_e_sop   = r_first;
        w_e_eop   = 1'b1;
        w_e_empty = EMPTY_W'(BYTES_R - r_res);
        w_n_first = 1'b0;
        w_nstate  = S_HEAD;
      end
    end else if (w_acc) begin
      // an accepted sop always restarts header processing, aborting any packet in progress
      if (bus.in_sop || r_state == S_HEAD) begin
        w_drop    = bus.in_sop && (r_state == S_ACC);
        w_nstate  = S_HEAD;
        w_n_first = 1'b1;
        w_n_cnt   = (&w_idx) ? w_idx : w_idx + 1'b1;
        if (w_idx < HDR_W'(w_skip)) begin
          if (bus.in_eop) w_drop = 1'b1;
        end else begin
          w_n_res      = w_vb - RW'(w_off);
          w_n_res_data = bus.in_data << {w_off, 3'b000};
          if (!bus.in_eop) begin
            w_nstate = S_ACC;
          end else if (w_vb > RW'(w_off)) begin
            w_emit    = 1'b1;
            w_e_data  = w_n_res_data;
            w_e_sop   = 1'b1;
            w_e_eop   = 1'b1;
            w_e_empty = EMPTY_W'(BYTES_R - w_n_res);
          end else begin
            w_drop = 1'b1;
          end
        end
      end else begin
        w_emit       = 1'b1;
        w_e_sop      = r_first;
        w_n_first    = 1'b0;
        w_n_res      = w_total - BYTES_R;
        w_n_res_data = bus.in_data << {BYTES_R - r_res, 3'b000};
        if (bus.in_eop) begin
          if (w_total <= BYTES_R) begin
            w_e_eop   = 1'b1;
            w_e_empty = EMPTY_W'(BYTES_R - w_total);
            w_nstate  = S_HEAD;
          end else begin
            w_nstate = S_FLUSH;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HEAD;
      r_cnt      <= '0;
      r_skip     <= '0;
      r_off      <= '0;
      r_res      <= '0;
      r_res_data <= '0;
      r_first    <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_cnt      <= w_n_cnt;
      r_res      <= w_n_res;
      r_res_data <= w_n_res_data;
      r_first    <= w_n_first;
      if (w_acc && bus.in_sop) begin
        r_skip <= w_skip;
        r_off  <= w_off;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= '0;
      r_out_data  <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_sop   <= w_e_sop;
      r_out_eop   <= w_e_eop;
      r_out_empty <= w_e_empty;
      r_out_data  <= w_e_data;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sop   = r_out_sop;
  assign bus.out_eop   = r_out_eop;
  assign bus.out_empty = r_out_empty;
  assign bus.out_data  = r_out_data;

`ifdef PAYLOAD_ALIGNER_STATS_EN
  logic [31:0] r_pkt_cnt, r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_out_valid && bus.out_ready && r_out_eop) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_drop) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign stat_pkt_cnt  = r_pkt_cnt;
  assign stat_drop_cnt = r_drop_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif
endmodule

// File: tb/tb_payload_aligner.sv
// tb/tb_payload_aligner.sv - scoreboard bench for payload_aligner with a byte-queue reference model
module tb_payload_aligner;
  localparam int DATA_W = 512;
  localparam int HDR_W  = 9;
  localparam int EW     = 6;
  localparam int B      = 64;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [EW-1:0]     empty;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_pkts = 0;
  int   m_drops = 0;
  bit   bp = 1'b0;
  bit   hold_ready = 1'b1;

  exp_t              mon_e;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [EW+1:0]     prev_ctl;
  logic [DATA_W-1:0] mon_mask;

  payload_aligner_if #(.DATA_W(DATA_W), .HDR_W(HDR_W), .EMPTY_W(EW)) bus ();

`ifdef PAYLOAD_ALIGNER_STATS_EN
  logic [31:0] stat_pkt_cnt;
  logic [31:0] stat_drop_cnt;
`endif

  payload_aligner #(.DATA_W(DATA_W), .HDR_W(HDR_W), .EMPTY_W(EW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef PAYLOAD_ALIGNER_STATS_EN
    .stat_pkt_cnt (stat_pkt_cnt),
    .stat_drop_cnt(stat_drop_cnt),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic drive_flit(input logic [DATA_W-1:0] d, input logic sop, input logic eop,
                            input logic [EW-1:0] emp, input logic [HDR_W-1:0] hdr);
    int n = 0;
    bus.in_valid   = 1'b1;
    bus.in_data    = d;
    bus.in_sop     = sop;
    bus.in_eop     = eop;
    bus.in_empty   = emp;
    bus.in_hdr_len = hdr;
    @(negedge clk);
    while (!bus.in_ready) begin
      n++;
      if (n > 1000) begin
        $display("FAIL in_ready_timeout: got 0 want 1");
        $fatal(1, "stuck waiting for in_ready");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.in_sop     = 1'($urandom);
    bus.in_eop     = 1'($urandom);
    bus.in_empty   = EW'($urandom);
    bus.in_hdr_len = HDR_W'($urandom);
  endtask

  // reference: concatenate valid bytes, drop hdr of them, cut the rest into left-aligned flits
  task automatic send_pkt(input int hdr, input int len, input bit gaps);
    logic [7:0]        pb[$];
    logic [DATA_W-1:0] d;
    exp_t              e;
    int                nfl, plen, nout;
    for (int i = 0; i < len; i++) pb.push_back(8'($urandom));
    nfl  = (len + B - 1) / B;
    plen = len - hdr;
    if (plen > 0) begin
      nout = (plen + B - 1) / B;
      for (int f = 0; f < nout; f++) begin
        e.data = '0;
        for (int k = 0; k < B; k++)
          if (f * B + k < plen) e.data[DATA_W-1-8*k -: 8] = pb[hdr + f * B + k];
        e.sop   = (f == 0);
        e.eop   = (f == nout - 1);
        e.empty = e.eop ? EW'(nout * B - plen) : '0;
        exp_q.push_back(e);
      end
      m_pkts++;
    end else begin
      m_drops++;
    end
    for (int f = 0; f < nfl; f++) begin
      for (int k = 0; k < B; k++)
        d[DATA_W-1-8*k -: 8] = (f * B + k < len) ? pb[f * B + k] : 8'($urandom);
      drive_flit(d, f == 0, f == nfl - 1, (f == nfl - 1) ? EW'(nfl * B - len) : EW'($urandom),
                 (f == 0) ? HDR_W'(hdr) : HDR_W'($urandom));
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (!hold_ready) bus.out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_data", bus.out_data, prev_data);
          chk("hold_ctl", {bus.out_sop, bus.out_eop, bus.out_empty}, prev_ctl);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", bus.out_valid, 0);
          end else begin
            mon_e    = exp_q.pop_front();
            mon_mask = ~({DATA_W{1'b1}} >> ((B - int'(mon_e.empty)) * 8));
            chk("out_ctl", {bus.out_sop, bus.out_eop, bus.out_empty}, {mon_e.sop, mon_e.eop, mon_e.empty});
            chk("out_data", bus.out_data & mon_mask, mon_e.data & mon_mask);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_ctl   = {bus.out_sop, bus.out_eop, bus.out_empty};
      end
    end
  end

  initial begin : main
    logic [DATA_W-1:0] d0, d1;
    exp_t              e;
    int                n;
    bus.in_valid   = 1'b0;
    bus.in_sop     = 1'b0;
    bus.in_eop     = 1'b0;
    bus.in_data    = '0;
    bus.in_empty   = '0;
    bus.in_hdr_len = '0;
    bus.out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_ctl", {bus.out_sop, bus.out_eop, bus.out_empty}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", bus.out_valid, 0);
    chk("post_rst_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    hold_ready = 1'b0;

    send_pkt(54, 182, 1'b0);
    send_pkt(0, 44, 1'b0);
    send_pkt(64, 128, 1'b0);
    send_pkt(20, 128, 1'b0);
    chk("flush_stall", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("flush_release", bus.in_ready, 1);
    send_pkt(60, 54, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    chk("directed_drain", exp_q.size(), 0);

    // stall mid-packet, then reset mid-packet
    hold_ready    = 1'b1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < DATA_W / 32; k++) begin
      d0[k*32 +: 32] = $urandom;
      d1[k*32 +: 32] = $urandom;
    end
    e.data  = d0;
    e.sop   = 1'b1;
    e.eop   = 1'b0;
    e.empty = '0;
    exp_q.push_back(e);
    drive_flit(d0, 1'b1, 1'b0, '0, '0);
    drive_flit(d1, 1'b0, 1'b0, '0, '0);
    repeat (5) @(negedge clk);
    chk("stall_valid", bus.out_valid, 1);
    chk("stall_data", bus.out_data, d0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_ready", bus.in_ready, 0);
    chk("midrst_consumed", exp_q.size(), 0);
    @(posedge clk); #1;
    rst_n      = 1'b1;
    m_pkts     = 0;
    m_drops    = 0;
    hold_ready = 1'b0;
    @(negedge clk);
    chk("after_rst_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    send_pkt(30, 150, 1'b0);

    bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_pkt(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 140)),
               int'($urandom_range(1, 320)), 1'b1);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    bp = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("final_drain", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
`ifdef PAYLOAD_ALIGNER_STATS_EN
    chk("stat_pkt_cnt", stat_pkt_cnt, m_pkts);
    chk("stat_drop_cnt", stat_drop_cnt, m_drops);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
